// File: rtl/proto_alu_pkg.sv
// rtl/proto_alu_pkg.sv - shared types for the proto ALU core
package proto_alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/proto_alu_muldiv.sv
// rtl/proto_alu_muldiv.sv - iterative shift-add multiplier / restoring divider
module proto_alu_muldiv
  import proto_alu_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [width-1:0] operand_a,
  input  logic [width-1:0] operand_b,
  output logic             step_done,
  output logic [width-1:0] result
);

  localparam int CW = $clog2(width + 1);

  // acc: product accumulator / partial remainder
  // x:   multiplier / dividend shifting into quotient
  // y:   multiplicand / divisor
  logic [width-1:0] acc_q, acc_d;
  logic [width-1:0] x_q, x_d;
  logic [width-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic [width-1:0] mul_acc;
  logic [width:0]   div_r;
  logic             div_ge;
  logic [width-1:0] div_sub;

  always_comb begin
    mul_acc = acc_q + (x_q[0] ? y_q : '0);
    div_r   = {acc_q, x_q[width-1]};
    div_ge  = (div_r >= {1'b0, y_q});
    // the true difference is below the divisor, so width bits suffice
    div_sub = div_r[width-1:0] - y_q;

    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;

    if (start) begin
      acc_d  = '0;
      x_d    = mode ? operand_a : operand_b;
      y_d    = mode ? operand_b : operand_a;
      cnt_d  = CW'(width);
      mode_d = mode;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (mode_q) begin
        acc_d = div_ge ? div_sub : div_r[width-1:0];
        x_d   = {x_q[width-2:0], div_ge};
      end else begin
        acc_d = mul_acc;
        x_d   = x_q >> 1;
        y_d   = y_q << 1;
      end
    end

    step_done = (cnt_q == CW'(1));
    result    = mode_q ? {x_q[width-2:0], div_ge} : mul_acc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/proto_alu_core.sv
// rtl/proto_alu_core.sv - request/valid ALU with single-cycle ADD/SUB and iterative MUL/DIV
module proto_alu_core
  import proto_alu_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             request,
  input  logic [width-1:0] operandA,
  input  logic [width-1:0] operandB,
  input  logic [1:0]       opcode,
  output logic [width-1:0] result,
  output logic             valid
);

  state_e           state_q, state_d;
  logic [width-1:0] result_q, result_d;
  logic             valid_q, valid_d;

  logic             md_start;
  logic             md_mode;
  logic             md_step_done;
  logic [width-1:0] md_result;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    valid_d  = valid_q;
    md_start = 1'b0;
    md_mode  = (opcode_e'(opcode) == DIV);

    unique case (state_q)
      IDLE: begin
        if (request) begin
          unique case (opcode_e'(opcode))
            ADD: begin
              result_d = operandA + operandB;
              state_d  = DONE;
              valid_d  = 1'b1;
            end
            SUB: begin
              result_d = operandA - operandB;
              state_d  = DONE;
              valid_d  = 1'b1;
            end
            default: begin
              md_start = 1'b1;
              state_d  = BUSY;
            end
          endcase
        end
      end
      BUSY: begin
        if (md_step_done) begin
          result_d = md_result;
          state_d  = DONE;
          valid_d  = 1'b1;
        end
      end
      DONE: begin
        if (!request) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  proto_alu_muldiv #(.width(width)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (md_start),
    .mode      (md_mode),
    .operand_a (operandA),
    .operand_b (operandB),
    .step_done (md_step_done),
    .result    (md_result)
  );

  assign result = result_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_proto_alu_core.sv
// tb/tb_proto_alu_core.sv - self-checking bench for proto_alu_core
module tb_proto_alu_core;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         request;
  logic [W-1:0] operandA;
  logic [W-1:0] operandB;
  logic [1:0]   opcode;
  logic [W-1:0] result;
  logic         valid;

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] last_result;

  always #5 clk = ~clk;

  proto_alu_core #(.width(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .request  (request),
    .operandA (operandA),
    .operandB (operandB),
    .opcode   (opcode),
    .result   (result),
    .valid    (valid)
  );

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
      end
      default: return (b == '0) ? {W{1'b1}} : a / b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit scramble, input bit drop_req);
    logic [W-1:0] exp;
    int  lat;
    int  want_lat;
    bit  early_change;
    bit  drop;
    exp          = model(op, a, b);
    want_lat     = op[1] ? W + 1 : 1;
    drop         = drop_req & op[1];
    operandA     = a;
    operandB     = b;
    opcode       = op;
    request      = 1'b1;
    lat          = 0;
    early_change = 1'b0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (valid) break;
      if (result !== last_result) early_change = 1'b1;
      if (scramble) begin
        operandA = $urandom;
        operandB = $urandom;
        opcode   = 2'($urandom);
      end
      if (drop) request = 1'b0;
    end
    check({tag, " latency"}, W'(lat), W'(want_lat));
    check({tag, " result"}, result, exp);
    check({tag, " result held while busy"}, W'(early_change), '0);
    if (!drop) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " valid held"}, W'(valid), W'(1));
      request = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, " valid falls"}, W'(valid), '0);
    check({tag, " result kept"}, result, exp);
    last_result = exp;
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b;
    bit           saw_valid;

    reset    = 1'b0;
    request  = 1'b1;
    operandA = 5;
    operandB = 7;
    opcode   = 2'b00;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("reset valid", W'(valid), '0);
      check("reset result", result, '0);
    end
    reset       = 1'b1;
    last_result = '0;

    run_op("add 5+7", 2'b00, 5, 7, 0, 0);
    run_op("add wrap", 2'b00, 32'hFFFF_FFFF, 2, 0, 0);
    run_op("sub wrap", 2'b01, 3, 5, 0, 0);
    run_op("mul", 2'b10, 32'h0001_0000, 32'h0001_0001, 0, 0);
    run_op("mul zero", 2'b10, 0, 32'hDEAD_BEEF, 0, 0);
    run_op("div", 2'b11, 100, 7, 0, 0);
    run_op("div by zero", 2'b11, 5, 0, 0, 0);
    run_op("mul scramble", 2'b10, 32'h1234_5678, 32'h9ABC_DEF1, 1, 0);
    run_op("div scramble", 2'b11, 32'hFFFF_FFF0, 13, 1, 0);
    run_op("div drop", 2'b11, 1000, 3, 0, 1);

    // reset ten cycles into a multiply must abort it silently
    operandA = 32'h0000_0123;
    operandB = 32'h0000_0456;
    opcode   = 2'b10;
    request  = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    request = 1'b0;
    reset   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort valid", W'(valid), '0);
    check("abort result", result, '0);
    reset     = 1'b1;
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) saw_valid = 1'b1;
    end
    check("abort no late valid", W'(saw_valid), '0);
    last_result = '0;
    run_op("after abort", 2'b10, 32'h0000_0123, 32'h0000_0456, 0, 0);

    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 15));
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b,
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
